// File: rtl/parity_frame_pkg.sv
// Shared types for the parity frame receiver.
// FSM state encoding and parity mode constants.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity check of an assembled frame.
// In: data, parity_bit, odd_mode. Out: error (1 = mismatch).
module parity_calc #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  input  logic              parity_bit,
  input  logic              odd_mode,
  output logic              error
);

  assign error = (^{parity_bit, data}) ^ odd_mode;

endmodule

// File: rtl/parity_frame_rx_ctrl.sv
// Serial parity frame receiver: start, DATA_W bits LSB first, parity, stop.
// Ports: bit_en/ser_in/odd_mode in; out_* valid/ready; flags, err_count, busy.
module parity_frame_rx_ctrl
  import parity_frame_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_en,
  input  logic                 ser_in,
  input  logic                 odd_mode,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_count,
  output logic                 busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic               r_odd;
  logic               r_par;
  logic               r_busy;

  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;
  logic [ERR_CNT_W-1:0] r_err;

  logic w_done;
  logic w_perr;
  logic w_ferr;
  logic w_load;
  logic w_drop;

  parity_calc #(
    .DATA_W(DATA_W)
  ) u_calc (
    .data      (r_shift),
    .parity_bit(r_par),
    .odd_mode  (r_odd),
    .error     (w_perr)
  );

  // The stop strobe itself completes the frame; stop value is live.
  assign w_done = bit_en && (r_state == STOP);
  assign w_ferr = ~ser_in;
  assign w_load = w_done && (!r_valid || out_ready);
  assign w_drop = w_done && r_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_odd   <= EVEN;
      r_par   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (bit_en) begin
      unique case (r_state)
        IDLE: begin
          if (!ser_in) begin
            r_state <= DATA;
            r_cnt   <= '0;
            r_odd   <= odd_mode;
            r_busy  <= 1'b1;
          end
        end
        DATA: begin
          // Shift right so the first bit ends up in bit 0.
          r_shift <= (r_shift >> 1)
                   | (DATA_W'(ser_in) << (DATA_W - 1));
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) r_state <= PARITY;
        end
        PARITY: begin
          r_par   <= ser_in;
          r_state <= STOP;
        end
        STOP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_err   <= '0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_perr  <= w_perr;
        r_ferr  <= w_ferr;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end

      if (clr_count) begin
        r_ovr <= 1'b0;
        r_err <= '0;
      end else begin
        if (w_drop) r_ovr <= 1'b1;
        // Dropped frames still count; saturate at all-ones.
        if (w_done && (w_perr || w_ferr) && (r_err != '1))
          r_err <= r_err + ERR_CNT_W'(1);
      end
    end
  end

  assign out_data    = r_data;
  assign out_valid   = r_valid;
  assign parity_err  = r_perr;
  assign framing_err = r_ferr;
  assign overrun     = r_ovr;
  assign err_count   = r_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_parity_frame_rx_ctrl.sv
// Bench for parity_frame_rx_ctrl: frame-level model plus directed frames.
// Two instances: default counter width and a 2-bit saturating counter.
module tb_parity_frame_rx_ctrl;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_en = 1'b0;
  logic ser_in = 1'b1;
  logic odd_mode = 1'b0;
  logic out_ready = 1'b1;
  logic clr_count = 1'b0;

  logic [DW-1:0] out_data;
  logic          out_valid, parity_err, framing_err, overrun, busy;
  logic [7:0]    err_count;

  logic [DW-1:0] d2_data;
  logic          d2_valid, d2_perr, d2_ferr, d2_ovr, d2_busy;
  logic [1:0]    d2_err;

  always #5 clk = ~clk;

  parity_frame_rx_ctrl #(.DATA_W(DW), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .ser_in(ser_in),
    .odd_mode(odd_mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .parity_err(parity_err),
    .framing_err(framing_err), .overrun(overrun),
    .err_count(err_count), .clr_count(clr_count), .busy(busy)
  );

  parity_frame_rx_ctrl #(.DATA_W(DW), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .ser_in(ser_in),
    .odd_mode(odd_mode), .out_data(d2_data), .out_valid(d2_valid),
    .out_ready(out_ready), .parity_err(d2_perr),
    .framing_err(d2_ferr), .overrun(d2_ovr),
    .err_count(d2_err), .clr_count(clr_count), .busy(d2_busy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: collect bits after a start bit, judge the frame
  // by counting ones once DW+2 bits have arrived.
  logic          m_in;
  logic          q[$];
  logic          m_odd;
  logic [DW-1:0] m_data;
  logic          m_valid, m_perr, m_ferr, m_ovr;
  int            m_err, m_err2;
  logic          done, np, nf;
  logic [DW-1:0] nd;
  int            ones;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in = 0; q.delete(); m_odd = 0; m_data = '0;
      m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
      m_err = 0; m_err2 = 0;
    end else begin
      done = 0; np = 0; nf = 0; nd = '0;
      if (bit_en) begin
        if (!m_in) begin
          if (!ser_in) begin
            m_in = 1; m_odd = odd_mode; q.delete();
          end
        end else begin
          q.push_back(ser_in);
          if (q.size() == DW + 2) begin
            done = 1;
            for (int i = 0; i < DW; i++) nd[i] = q[i];
            ones = $countones(nd) + int'(q[DW]);
            np = ((ones % 2) == 1) != m_odd;
            nf = !q[DW+1];
            m_in = 0;
          end
        end
      end
      if (done) begin
        if (!m_valid || out_ready) begin
          m_data = nd; m_perr = np; m_ferr = nf; m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (clr_count) begin
        m_ovr = 0; m_err = 0; m_err2 = 0;
      end else if (done && (np || nf)) begin
        if (m_err < 255) m_err++;
        if (m_err2 < 3) m_err2++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 32'(out_valid), 32'(m_valid));
      chk("data", 32'(out_data), 32'(m_data));
      chk("perr", 32'(parity_err), 32'(m_perr));
      chk("ferr", 32'(framing_err), 32'(m_ferr));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_in));
      chk("d2_valid", 32'(d2_valid), 32'(m_valid));
      chk("d2_data", 32'(d2_data), 32'(m_data));
      chk("d2_perr", 32'(d2_perr), 32'(m_perr));
      chk("d2_ferr", 32'(d2_ferr), 32'(m_ferr));
      chk("d2_ovr", 32'(d2_ovr), 32'(m_ovr));
      chk("d2_err", 32'(d2_err), 32'(m_err2));
      chk("d2_busy", 32'(d2_busy), 32'(m_in));
    end
  end

  task automatic strobe(input logic b, input bit gap);
    bit_en = 1'b1; ser_in = b;
    @(posedge clk); #1;
    bit_en = 1'b0; ser_in = 1'b1;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input logic [DW-1:0] d, input logic par,
                       input logic stp, input logic odd,
                       input bit gap, input bit clr_stop);
    odd_mode = odd;
    strobe(1'b0, gap);
    odd_mode = ~odd;
    for (int i = 0; i < DW; i++) strobe(d[i], gap);
    strobe(par, gap);
    clr_count = clr_stop;
    strobe(stp, 1'b0);
    clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chk(nm, act, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("rst_data", 32'(out_data), 0);
    lit("rst_valid", 32'(out_valid), 0);
    lit("rst_busy", 32'(busy), 0);
    lit("rst_err", 32'(err_count), 0);
    lit("rst_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame(4'hB, 1'b1, 1'b1, 1'b0, 1, 0);
    lit("f1_data", 32'(out_data), 32'hB);
    lit("f1_perr", 32'(parity_err), 0);
    lit("f1_ferr", 32'(framing_err), 0);
    lit("f1_err", 32'(err_count), 0);

    frame(4'hB, 1'b0, 1'b1, 1'b0, 1, 0);
    lit("f2_data", 32'(out_data), 32'hB);
    lit("f2_perr", 32'(parity_err), 1);
    lit("f2_err", 32'(err_count), 1);

    frame(4'h3, 1'b1, 1'b1, 1'b1, 1, 0);
    lit("f3_data", 32'(out_data), 32'h3);
    lit("f3_perr", 32'(parity_err), 0);

    frame(4'h5, 1'b0, 1'b0, 1'b0, 0, 0);
    lit("f4_ferr", 32'(framing_err), 1);
    lit("f4_perr", 32'(parity_err), 0);
    lit("f4_err", 32'(err_count), 2);
    frame(4'hA, 1'b0, 1'b1, 1'b0, 0, 0);
    lit("f5_data", 32'(out_data), 32'hA);
    lit("f5_ferr", 32'(framing_err), 0);

    out_ready = 1'b0;
    frame(4'h6, 1'b0, 1'b1, 1'b0, 1, 0);
    frame(4'h9, 1'b1, 1'b1, 1'b0, 1, 0);
    lit("ovr_data", 32'(out_data), 32'h6);
    lit("ovr_valid", 32'(out_valid), 1);
    lit("ovr_flag", 32'(overrun), 1);
    lit("ovr_perr", 32'(parity_err), 0);
    lit("ovr_err", 32'(err_count), 3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    lit("acc_valid", 32'(out_valid), 0);
    lit("acc_data", 32'(out_data), 32'h6);
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    lit("clr_ovr", 32'(overrun), 0);
    lit("clr_err", 32'(err_count), 0);

    for (int k = 0; k < 5; k++) frame(4'hB, 1'b0, 1'b1, 1'b0, 0, 0);
    lit("sat_err2", 32'(d2_err), 3);
    lit("sat_err8", 32'(err_count), 5);
    frame(4'hB, 1'b0, 1'b1, 1'b0, 0, 1);
    lit("satclr_err2", 32'(d2_err), 0);
    lit("satclr_err8", 32'(err_count), 0);
    lit("satclr_perr", 32'(parity_err), 1);

    odd_mode = 1'b0;
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    rst_n = 1'b0;
    #2;
    lit("mrst_data", 32'(out_data), 0);
    lit("mrst_perr", 32'(parity_err), 0);
    lit("mrst_busy", 32'(busy), 0);
    lit("mrst_err", 32'(err_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame(4'hC, 1'b0, 1'b1, 1'b0, 1, 0);
    lit("post_data", 32'(out_data), 32'hC);
    lit("post_perr", 32'(parity_err), 0);
    lit("post_ferr", 32'(framing_err), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
